// File: rtl/encoder4x2_pend_pkg.sv
// Shared widths, FSM encoding and the index-to-mask helper for the
// 4-to-2 pending-request encoder.
package encoder4x2_pend_pkg;

  localparam int REQ_W  = 4;
  localparam int CODE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [REQ_W-1:0] onehot(input logic [CODE_W-1:0] idx);
    return {{(REQ_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/encoder4x2_pend_pri_enc4.sv
// Combinational 4-bit priority selector; LSB_FIRST picks which end of the
// request vector wins.
module pri_enc4
  import encoder4x2_pend_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic [REQ_W-1:0]  req,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    idx = '0;
    any = |req;
    // Scan toward the winning end; the last hit in the scan is the winner.
    if (LSB_FIRST) begin
      for (int i = REQ_W - 1; i >= 0; i--) begin
        if (req[i]) idx = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < REQ_W; i++) begin
        if (req[i]) idx = CODE_W'(i);
      end
    end
  end

endmodule

// File: rtl/encoder4x2_pend.sv
// Pending-request priority encoder: captures request bits into a sticky
// register and issues them one at a time with a valid/ack handshake.
module encoder4x2_pend
  import encoder4x2_pend_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [REQ_W-1:0]  w,
  input  logic              ack,
  output logic [CODE_W-1:0] y,
  output logic              valid,
  output logic [REQ_W-1:0]  pend,
  output logic              ovf
);

  state_t              state;
  logic                load;
  logic                any;
  logic [CODE_W-1:0]   sel;
  logic [REQ_W-1:0]    issue_mask;
  logic [REQ_W-1:0]    capture;

  // Selection looks only at registered pend, never at this cycle's w.
  pri_enc4 #(.LSB_FIRST(LSB_FIRST)) u_pri (
    .req (pend),
    .idx (sel),
    .any (any)
  );

  always_comb begin
    load       = (state == IDLE) || ack;
    issue_mask = (load && any) ? onehot(sel) : '0;
    capture    = en ? w : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      state <= IDLE;
      y     <= '0;
      valid <= 1'b0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      // A bit set and issued on the same edge stays set: the new request wins.
      pend <= (pend & ~issue_mask) | capture;
      if (|(capture & pend & ~issue_mask)) ovf <= 1'b1;
      if (load) begin
        if (any) begin
          y     <= sel;
          valid <= 1'b1;
          state <= HOLD;
        end else begin
          valid <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_encoder4x2_pend.sv
// Self-checking bench for encoder4x2_pend: directed vector table plus a
// randomised phase against a behavioural model, both via a scoreboard queue.
module tb_encoder4x2_pend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] w   = 4'h0;

  logic [1:0] y0, y1;
  logic       valid0, valid1, ovf0, ovf1;
  logic [3:0] pend0, pend1;

  always #5 clk = ~clk;

  encoder4x2_pend #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .en(en), .w(w), .ack(ack),
    .y(y0), .valid(valid0), .pend(pend0), .ovf(ovf0)
  );

  encoder4x2_pend #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .w(w), .ack(ack),
    .y(y1), .valid(valid1), .pend(pend1), .ovf(ovf1)
  );

  typedef struct packed {
    logic [3:0] pend;
    logic [1:0] y;
    logic       valid;
    logic       ovf;
  } out_t;

  typedef struct {
    bit         rst, en, ack;
    logic [3:0] w;
    out_t       e0;
    bit         c1;
    logic [1:0] y1;
    logic       v1;
  } vec_t;

  typedef struct {
    out_t e0;
    out_t e1;
    bit   c1y;
    bit   c1all;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[$];
  int    errors = 0;
  int    checks = 0;
  string tag;
  out_t  m0, m1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit e, logic [3:0] ww, bit a,
                              logic [3:0] p, logic [1:0] yy, logic v, logic o,
                              bit c1, logic [1:0] y1, logic v1);
    vec_t t;
    t.rst = r; t.en = e; t.w = ww; t.ack = a;
    t.e0 = '{pend: p, y: yy, valid: v, ovf: o};
    t.c1 = c1; t.y1 = y1; t.v1 = v1;
    return t;
  endfunction

  // Behavioural reference: one clock edge of the encoder.
  function automatic out_t model(out_t s, bit lsb, bit r, bit e, bit a, logic [3:0] ww);
    out_t       n;
    logic [3:0] iss;
    n   = s;
    iss = 4'h0;
    if (r) return '0;
    if (!s.valid || a) begin
      if (s.pend == 4'h0) begin
        n.valid = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          int b;
          b = lsb ? k : 3 - k;
          if (s.pend[b] && iss == 4'h0) begin
            iss[b] = 1'b1;
            n.y    = 2'(b);
          end
        end
        n.valid = 1'b1;
      end
    end
    if (e && |(ww & s.pend & ~iss)) n.ovf = 1'b1;
    n.pend = (s.pend & ~iss) | (e ? ww : 4'h0);
    return n;
  endfunction

  task automatic compare();
    exp_t ex;
    ex = sb.pop_front();
    check("pend0",  pend0,           ex.e0.pend);
    check("y0",     {2'b00, y0},     {2'b00, ex.e0.y});
    check("valid0", {3'b000, valid0}, {3'b000, ex.e0.valid});
    check("ovf0",   {3'b000, ovf0},  {3'b000, ex.e0.ovf});
    if (ex.c1y || ex.c1all) begin
      check("y1",     {2'b00, y1},      {2'b00, ex.e1.y});
      check("valid1", {3'b000, valid1}, {3'b000, ex.e1.valid});
    end
    if (ex.c1all) begin
      check("pend1", pend1,          ex.e1.pend);
      check("ovf1",  {3'b000, ovf1}, {3'b000, ex.e1.ovf});
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit a, input logic [3:0] ww,
                       input exp_t ex);
    @(negedge clk);
    rst = r; en = e; ack = a; w = ww;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    exp_t ex;
    bit   r, e, a;
    logic [3:0] ww;

    // Reset with every other input active
    vecs.push_back(mk(1, 1, 4'hF, 1, 4'h0, 2'd0, 0, 0, 1, 2'd0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 1, 4'h0, 2'd0, 0, 0, 1, 2'd0, 0));
    // Single request, held until ack, ack in IDLE ignored, en=0 drops w
    vecs.push_back(mk(0, 1, 4'h4, 0, 4'h4, 2'd0, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 2'd2, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 2'd2, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h0, 2'd2, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h0, 2'd2, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'hF, 0, 4'h0, 2'd2, 0, 0, 0, 2'd0, 0));
    // Priority drain of 1011 with ack held, both priority orders
    vecs.push_back(mk(0, 1, 4'hB, 1, 4'hB, 2'd2, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h3, 2'd3, 1, 0, 1, 2'd0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h1, 2'd1, 1, 0, 1, 2'd1, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h0, 2'd0, 1, 0, 1, 2'd3, 1));
    vecs.push_back(mk(0, 0, 4'h0, 1, 4'h0, 2'd0, 0, 0, 1, 2'd3, 0));
    // Overflow: merge into pending bit sets ovf, en=0 repeat does not
    vecs.push_back(mk(0, 1, 4'h1, 0, 4'h1, 2'd0, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 2'd0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 4'h2, 2'd0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h2, 0, 4'h2, 2'd0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 4'h2, 2'd0, 1, 1, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h2, 0, 4'h2, 2'd0, 1, 1, 0, 2'd0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 1, 4'h0, 2'd0, 0, 0, 0, 2'd0, 0));
    // Set and issue of the same bit on one edge: set wins, no ovf
    vecs.push_back(mk(0, 1, 4'h1, 0, 4'h1, 2'd0, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'h1, 0, 4'h1, 2'd0, 1, 0, 0, 2'd0, 0));
    // Reset mid-HOLD with pend=1100, then fresh capture
    vecs.push_back(mk(0, 1, 4'hC, 1, 4'hC, 2'd0, 1, 0, 0, 2'd0, 0));
    vecs.push_back(mk(1, 1, 4'hF, 0, 4'h0, 2'd0, 0, 0, 1, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 2'd0, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'h2, 0, 4'h2, 2'd0, 0, 0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 0, 4'h0, 2'd1, 1, 0, 0, 2'd0, 0));

    foreach (vecs[i]) begin
      tag      = $sformatf("vec%0d", i);
      ex.e0    = vecs[i].e0;
      ex.e1    = '{pend: 4'h0, y: vecs[i].y1, valid: vecs[i].v1, ovf: 1'b0};
      ex.c1y   = vecs[i].c1;
      ex.c1all = 1'b0;
      drive(vecs[i].rst, vecs[i].en, vecs[i].ack, vecs[i].w, ex);
    end

    // Random traffic against the model, both priority orders
    m0 = '0;
    m1 = '0;
    for (int i = 0; i < 400; i++) begin
      r  = (i == 0) || ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 2) != 0);
      ww = 4'($urandom_range(0, 15));
      m0 = model(m0, 1'b0, r, e, a, ww);
      m1 = model(m1, 1'b1, r, e, a, ww);
      tag      = $sformatf("rnd%0d", i);
      ex.e0    = m0;
      ex.e1    = m1;
      ex.c1y   = 1'b0;
      ex.c1all = 1'b1;
      drive(r, e, a, ww, ex);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder4x2_pend.md
ENCODER4X2_PEND -- requirements
Module: encoder4x2_pend

Interface
REQ-001 Parameter LSB_FIRST, default 0, SHALL select priority: 0 = w[3] highest; 1 = w[0] highest.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 en  input  1  SHALL be the capture enable; w is sampled only when en=1.
REQ-005 w  input  4  SHALL carry request lines; each bit is an independent event, not one-hot-constrained.
REQ-006 ack  input  1  SHALL acknowledge the presented code; meaningful only while valid=1.
REQ-007 y  output  2  SHALL carry the binary index of the issued request bit.
REQ-008 valid  output  1  SHALL indicate y holds an unacknowledged code.
REQ-009 pend  output  4  SHALL expose the pending-request register.
REQ-010 ovf  output  1  SHALL be a sticky flag for a request lost by merging into an already-pending bit.

Function
REQ-011 Capture: at an edge with en=1, pend SHALL become (pend & ~issue_mask) | w; with en=0, pend SHALL become pend & ~issue_mask.
REQ-012 States: IDLE (valid=0) and HOLD (valid=1); no other states.
REQ-013 Load condition: load = (IDLE) or (HOLD and ack=1).
REQ-014 On load with pend != 0, y SHALL take the index of the highest-priority set bit of registered pend (not same-cycle w), valid SHALL be 1, and issue_mask SHALL be the one-hot of that index; otherwise issue_mask = 0.
REQ-015 On load with pend == 0, valid SHALL become 0 and y SHALL hold its previous value.
REQ-016 In HOLD with ack=0, y and valid SHALL remain stable.
REQ-017 ack while IDLE SHALL be ignored.
REQ-018 Latency: w bit asserted with en=1 at edge N SHALL appear in pend after edge N; the earliest valid=1 for it is after edge N+1.
REQ-019 Back-to-back: with ack held at 1 and pend non-empty, a new code SHALL issue every cycle.
REQ-020 Simultaneous set and issue of the same bit: set SHALL win (pend bit stays 1, counted as a new request, ovf unchanged).
REQ-021 ovf SHALL set at an edge where en=1, w[i]=1, pend[i]=1 and bit i is not being issued that cycle; ovf stays 1 until reset.
REQ-022 Request bits in w while en=0 SHALL be dropped without setting ovf.

Reset
REQ-023 With rst=1 at an edge: pend=0000, y=00, valid=0, ovf=0, state IDLE; rst SHALL override en, w and ack.
REQ-024 Reset mid-HOLD SHALL discard the presented code and all pending bits; w on the reset edge SHALL NOT be captured.
REQ-025 First capture after reset SHALL occur at the first edge with rst=0 and en=1.

Structure
REQ-026 A shared package SHALL hold the request width (4), code width (2) and the IDLE/HOLD state encoding.
REQ-027 One combinational sub-module pri_enc4 (4-bit in, LSB_FIRST parameter, 2-bit index out, any-set flag) SHALL implement priority selection; all registers stay in encoder4x2_pend.

Verification
REQ-028 Reset: drive rst=1 with en=1, w=1111, ack=1 for 2 cycles -> pend=0000, y=00, valid=0, ovf=0.
REQ-029 Single request: en=1, w=0100 for one cycle, ack=0 -> pend=0100 next cycle, then y=10, valid=1, pend=0000; y held until ack=1, then valid=0.
REQ-030 Priority drain: en=1, w=1011 for one cycle, ack=1 held, LSB_FIRST=0 -> y sequence 11, 01, 00, then valid=0; with LSB_FIRST=1 -> 00, 01, 11.
REQ-031 Overflow: w=0001 captured, hold ack=0 so code 00 is presented, w=0010 then w=0010 again -> ovf=1 on second capture; w with en=0 -> ovf unaffected.
REQ-032 Set-vs-issue: pend=0001, IDLE, en=1, w=0001 on the load edge -> y=00, valid=1, pend=0001, ovf=0.
REQ-033 Reset mid-HOLD: valid=1, pend=1100, assert rst one cycle -> all outputs zero next cycle; later en=1, w=0010 -> y=01 two edges later.
